peak_period_capture: RTL

PEAK_PERIOD_CAPTURE -- requirements
Module: peak_period_capture

---
 rtl/period_capture_pkg.sv | 13 +
 rtl/period_buf_ram.sv | 27 ++
 rtl/peak_period_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/period_capture_pkg.sv
// Shared FSM encoding and derivative midpoint for the peak-to-peak period capture block.
`timescale 1ns/1ps
package period_capture_pkg;

    localparam int MIDPOINT = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/period_buf_ram.sv
// Simple dual-port period buffer: one write port, one registered read port with enable.
`timescale 1ns/1ps
module period_buf_ram
    import period_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read data holds while rd_en is low so a stalled sample is not lost.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/peak_period_capture.sv
// Captures one waveform period between two derivative peaks and replays it as a ready/valid frame.
// Optional macro PERIOD_CAPTURE_MINLEN_EN rejects closing peaks that arrive before MIN_LEN samples.
`timescale 1ns/1ps
module peak_period_capture
    import period_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int HYST       = 4,
    parameter int MIN_LEN    = 8
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     deriv_valid,
    input  logic [DATA_WIDTH-1:0]    deriv_data,
    input  logic [DATA_WIDTH-1:0]    wave_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_first,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   period_len,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_WIDTH-1:0] ARM_TH    = DATA_WIDTH'(MIDPOINT - HYST);
    localparam logic [DATA_WIDTH-1:0] FIRE_TH   = DATA_WIDTH'(MIDPOINT + HYST);
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         MIN_CNT   = CW'(MIN_LEN);
`ifdef PERIOD_CAPTURE_MINLEN_EN
    localparam bit MINLEN_EN = 1'b1;
`else
    localparam bit MINLEN_EN = 1'b0;
`endif

    state_t          state, state_nxt;
    logic            armed, armed_nxt;
    logic [CW-1:0]   wr_cnt, wr_cnt_nxt;
    logic [CW-1:0]   plen_nxt;
    logic            ovf_nxt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            beat_live, peak;

    logic [CW-1:0]         rd_idx;
    logic                  rd_en, advance;
    logic                  vld_p0, first_p0, last_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    assign beat_live = deriv_valid && (state != DRAIN);
    assign peak      = beat_live && armed && (deriv_data >= FIRE_TH);

    always_comb begin
        state_nxt  = state;
        armed_nxt  = armed;
        wr_cnt_nxt = wr_cnt;
        plen_nxt   = period_len;
        ovf_nxt    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = wr_cnt[AW-1:0];

        if (beat_live) begin
            if (deriv_data <= ARM_TH) armed_nxt = 1'b1;
            else if (peak)            armed_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (peak) begin
                    state_nxt  = CAPTURE;
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_cnt_nxt = CW'(1);
                end
            end
            CAPTURE: begin
                if (wr_cnt == DEPTH_CNT) begin
                    ovf_nxt    = 1'b1;
                    state_nxt  = IDLE;
                    armed_nxt  = 1'b0;
                    wr_cnt_nxt = '0;
                end else if (peak && MINLEN_EN && (wr_cnt < MIN_CNT)) begin
                    // Too short to be a real period: the closing beat restarts the capture.
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_cnt_nxt = CW'(1);
                end else if (peak) begin
                    state_nxt  = DRAIN;
                    plen_nxt   = wr_cnt;
                    wr_cnt_nxt = '0;
                end else if (beat_live) begin
                    wr_en      = 1'b1;
                    wr_cnt_nxt = wr_cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            wr_cnt     <= '0;
            period_len <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            armed      <= armed_nxt;
            wr_cnt     <= wr_cnt_nxt;
            period_len <= plen_nxt;
            overflow   <= ovf_nxt;
        end
    end

    period_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_buf (
        .clk     (clk_50M),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wave_data),
        .rd_en   (rd_en),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (data_p0)
    );

    // p0: buffer read stage; output registers form the final stage and only advance when free.
    assign advance = !out_valid || out_ready;
    assign rd_en   = (state == DRAIN) && (rd_idx < period_len) && (!vld_p0 || advance);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            rd_idx    <= '0;
            vld_p0    <= 1'b0;
            first_p0  <= 1'b0;
            last_p0   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (state != DRAIN) rd_idx <= '0;
            else if (rd_en)     rd_idx <= rd_idx + CW'(1);

            if (rd_en) begin
                vld_p0   <= 1'b1;
                first_p0 <= (rd_idx == '0);
                last_p0  <= (rd_idx == period_len - CW'(1));
            end else if (advance) begin
                vld_p0   <= 1'b0;
            end

            if (advance) begin
                out_valid <= vld_p0;
                out_data  <= data_p0;
                out_first <= vld_p0 && first_p0;
                out_last  <= vld_p0 && last_p0;
            end
        end
    end

endmodule
